// File: rtl/tdm_demux.sv
// Serial TDM receiver: hunts for frame sync, then deserialises each
// fixed-width slot into its own channel register with a valid strobe.
module tdm_demux #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bit_en,
   input  logic                     din,
   input  logic                     frame_sync,
   output logic [NUM_CH*CH_W-1:0]   ch_data,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic                     frame_done,
   output logic                     locked,
   output logic                     sync_err
);

   localparam int BW = $clog2(CH_W);
   localparam int CW = $clog2(NUM_CH);
   localparam int SW = CH_W - 1;

   typedef enum logic {HUNT, RUN} state_t;

   state_t         state, nstate;
   logic [BW-1:0]  bit_cnt;
   logic [CW-1:0]  slot_cnt;
   logic [SW-1:0]  sh;

   logic           at_sync, slot_end, last_slot;
   logic           start, early, miss, adv, done_slot;
   logic [NUM_CH-1:0] valid_n;
   logic           done_n, err_n, lock_n;

   assign at_sync   = (bit_cnt == '0) && (slot_cnt == '0);
   assign slot_end  = (bit_cnt == BW'(CH_W - 1));
   assign last_slot = (slot_cnt == CW'(NUM_CH - 1));

   assign start     = bit_en && (state == HUNT) && frame_sync;
   assign early     = bit_en && (state == RUN) && frame_sync && !at_sync;
   assign miss      = bit_en && (state == RUN) && !frame_sync && at_sync;
   assign adv       = bit_en && (state == RUN) && !early && !miss;
   assign done_slot = adv && slot_end;

   always_ff @(posedge clk) begin
      if (rst) state <= HUNT;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      if (start)     nstate = RUN;
      else if (miss) nstate = HUNT;
   end

   always_comb begin
      valid_n = '0;
      for (int k = 0; k < NUM_CH; k++)
         valid_n[k] = done_slot && (slot_cnt == CW'(k));
      done_n = done_slot && last_slot;
      err_n  = early || miss;
      lock_n = (nstate == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt    <= '0;
         slot_cnt   <= '0;
         sh         <= '0;
         ch_data    <= '0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         ch_valid   <= valid_n;
         frame_done <= done_n;
         sync_err   <= err_n;
         locked     <= lock_n;
         // a sync bit always starts slot 0, discarding any partial slot
         if (start || early) begin
            sh       <= SW'(din);
            bit_cnt  <= BW'(1);
            slot_cnt <= '0;
         end else if (adv) begin
            sh <= SW'({sh, din});
            if (slot_end) begin
               bit_cnt  <= '0;
               slot_cnt <= last_slot ? '0 : slot_cnt + CW'(1);
            end else begin
               bit_cnt <= bit_cnt + BW'(1);
            end
         end
         for (int k = 0; k < NUM_CH; k++)
            if (valid_n[k])
               ch_data[k*CH_W +: CH_W] <= {sh, din};
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: directed frames with hand-computed
// channel bytes, stalls, early/missing sync and mid-frame reset.
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst, bit_en, din, frame_sync;
   logic [31:0] ch_data;
   logic [3:0]  ch_valid;
   logic        frame_done, locked, sync_err;

   always #5 clk = ~clk;

   tdm_demux #(.NUM_CH(4), .CH_W(8)) dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .din(din),
      .frame_sync(frame_sync), .ch_data(ch_data),
      .ch_valid(ch_valid), .frame_done(frame_done),
      .locked(locked), .sync_err(sync_err)
   );

   typedef struct {
      logic [3:0] vld;
      logic       fd;
      logic       err;
      logic [7:0] d;
      int         ch;
      int         due;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drv(input logic en, input logic d, input logic fs);
      @(negedge clk);
      rst = 1'b0;
      bit_en = en;
      din = d;
      frame_sync = fs;
   endtask

   task automatic push(input logic [3:0] vld, input logic fd,
                       input logic err, input logic [7:0] d, input int ch);
      exp_t e;
      e.vld = vld;
      e.fd  = fd;
      e.err = err;
      e.d   = d;
      e.ch  = ch;
      e.due = cyc + 1;
      q.push_back(e);
   endtask

   task automatic slot(input logic [7:0] b, input logic fs0, input int ch,
                       input logic stall, input logic err0, input logic lsb);
      for (int i = 7; i >= 0; i--) begin
         if (stall) drv(1'b0, ~b[i], 1'b1);
         drv(1'b1, b[i], (i == 7) ? fs0 : 1'b0);
         if (i == 7 && err0) push(4'b0000, 1'b0, 1'b1, 8'h00, 0);
         if (i == 0 && lsb) push(4'(1 << ch), ch == 3, 1'b0, b, ch);
      end
   endtask

   task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input logic stall);
      slot(b0, 1'b1, 0, stall, 1'b0, 1'b1);
      slot(b1, 1'b0, 1, stall, 1'b0, 1'b1);
      slot(b2, 1'b0, 2, stall, 1'b0, 1'b1);
      slot(b3, 1'b0, 3, stall, 1'b0, 1'b1);
   endtask

   always @(negedge clk) begin
      if (ch_valid != 4'b0 || frame_done || sync_err) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected: got vld %b fd %b err %b want none",
                     ch_valid, frame_done, sync_err);
         end else begin
            m = q.pop_front();
            chk("flags", {26'b0, ch_valid, frame_done, sync_err},
                {26'b0, m.vld, m.fd, m.err});
            chk("timing", cyc, m.due);
            if (m.vld != 4'b0)
               chk("slot_data", {24'b0, ch_data[m.ch*8 +: 8]}, {24'b0, m.d});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bit_en = 1'b0;
      din = 1'b0;
      frame_sync = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_data", ch_data, 32'h0);
      chk("rst_valid", {28'b0, ch_valid}, 32'h0);
      chk("rst_flags", {29'b0, frame_done, locked, sync_err}, 32'h0);

      frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0);
      drv(1'b0, 1'b0, 1'b0);
      chk("normal_data", ch_data, 32'h01FF3CA5);
      chk("normal_lock", {31'b0, locked}, 32'h1);

      frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1);
      drv(1'b0, 1'b0, 1'b0);
      chk("stall_data", ch_data, 32'h01FF3CA5);

      frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
      drv(1'b0, 1'b0, 1'b0);
      chk("b2b_data", ch_data, 32'h44332211);

      slot(8'h55, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      repeat (3) drv(1'b1, 1'b1, 1'b0);
      slot(8'h9A, 1'b1, 0, 1'b0, 1'b1, 1'b1);
      slot(8'hBC, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      slot(8'hDE, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      slot(8'hF0, 1'b0, 3, 1'b0, 1'b0, 1'b1);
      drv(1'b0, 1'b0, 1'b0);
      chk("early_data", ch_data, 32'hF0DEBC9A);
      chk("early_lock", {31'b0, locked}, 32'h1);

      slot(8'hAA, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      drv(1'b0, 1'b0, 1'b0);
      chk("miss_unlock", {31'b0, locked}, 32'h0);
      slot(8'h77, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      drv(1'b0, 1'b0, 1'b0);
      chk("hunt_hold", ch_data, 32'hF0DEBC9A);
      frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
      drv(1'b0, 1'b0, 1'b0);
      chk("relock_data", ch_data, 32'h78563412);
      chk("relock_lock", {31'b0, locked}, 32'h1);

      slot(8'h0F, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      slot(8'hF0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      repeat (4) drv(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      bit_en = 1'b1;
      din = 1'b1;
      frame_sync = 1'b1;
      drv(1'b0, 1'b0, 1'b0);
      chk("mrst_data", ch_data, 32'h0);
      chk("mrst_valid", {28'b0, ch_valid}, 32'h0);
      chk("mrst_flags", {29'b0, frame_done, locked, sync_err}, 32'h0);
      frame(8'hC3, 8'h5A, 8'h96, 8'h69, 1'b0);
      drv(1'b0, 1'b0, 1'b0);
      chk("post_rst_data", ch_data, 32'h69965AC3);
      chk("post_rst_lock", {31'b0, locked}, 32'h1);

      repeat (3) drv(1'b0, 1'b0, 1'b0);
      chk("sb_empty", q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the team's select-driven multiplexers.
- Takes a serial time-division-multiplexed bit stream, carried on one shared line with a frame-sync marker.
- Routes each fixed-width slot to its own parallel channel register and strobes that channel valid.
- Sits at the far end of a shared-line link, feeding per-channel consumers.

Parameters:
- NUM_CH, 4, number of channels (slots per frame); must be >= 2.
- CH_W, 8, bits per slot; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  qualifies din/frame_sync this cycle; when low, the block holds its position.
- din  input  1  serial data, MSB of each slot first.
- frame_sync  input  1  high with the first bit (MSB of slot 0) of a frame; sampled only when bit_en=1.
- ch_data  output  NUM_CH*CH_W  channel registers; channel k at bits [k*CH_W +: CH_W].
- ch_valid  output  NUM_CH  one-cycle pulse on bit k when channel k is updated.
- frame_done  output  1  one-cycle pulse, coincident with ch_valid[NUM_CH-1].
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle pulse on a sync violation.

Behaviour:
- Reset (clk edge with rst=1): state=HUNT; ch_data=0, ch_valid=0, frame_done=0, locked=0, sync_err=0; bit_cnt=0, slot_cnt=0, shift register=0. rst has priority over all other inputs. Reset mid-frame discards the partial slot; ch_data is cleared.
- All state advances only on cycles with bit_en=1. With bit_en=0, counters and shift register hold, and ch_valid/frame_done/sync_err are 0.
- HUNT state:
  - bit_en=1 with frame_sync=0: ignored.
  - bit_en=1 with frame_sync=1: go to RUN. din is captured as slot 0 bit CH_W-1. Next position is bit_cnt=1, slot_cnt=0.
- RUN state:
  - Each qualified bit shifts into the shift register (MSB first) and bit_cnt increments.
  - When bit_cnt=CH_W-1 is sampled (the slot's LSB), the next clock edge writes the completed byte into ch_data slice slot_cnt and pulses ch_valid[slot_cnt] for that single cycle. Latency is 1 clk after the LSB edge.
  - bit_cnt then wraps to 0 and slot_cnt increments. slot_cnt wraps NUM_CH-1 -> 0.
  - frame_done pulses with ch_valid[NUM_CH-1].
- Expected sync position is bit_cnt=0 and slot_cnt=0. In RUN, four cases apply:
  - frame_sync=1 at the expected position: normal; no error.
  - frame_sync=1 at any other position (early sync): sync_err pulses. The partial slot is discarded with no ch_valid for it. Realign: this bit becomes slot 0 MSB; stay in RUN.
  - frame_sync=0 at the expected position (missing sync): sync_err pulses; go to HUNT; locked=0. This bit is discarded.
  - Completion of slot NUM_CH-1 and the ch_valid write are never suppressed by a following sync error.
- ch_data slices not being written hold their value. At most one ch_valid bit is high per cycle.
- locked is registered: 1 from the cycle after the HUNT->RUN transition, 0 from the cycle after RUN->HUNT or reset.

Test Plan:
- Normal frame: rst, then bit_en=1 continuously, frame_sync on the first bit, slots 0xA5,0x3C,0xFF,0x01 -> ch_valid 0001,0010,0100,1000 each 1 clk after the respective 8th bit; frame_done with the last; ch_data=32'h01FF3CA5; locked=1; sync_err never asserted.
- Stall: same frame with bit_en low every other cycle, and bit_en=0 cycles carrying frame_sync=1 and din toggles -> identical ch_data=32'h01FF3CA5; pulses occur only after qualified LSBs; no sync_err.
- Back-to-back frames: second frame 0x11,0x22,0x33,0x44 with sync at the expected position -> ch_data=32'h44332211, 8 total ch_valid pulses, no sync_err.
- Early sync: frame_sync asserted at slot 1 bit 3 -> sync_err 1 clk; no ch_valid[1] for the partial slot; next 4 slots land in ch 0..3 correctly.
- Missing sync: next frame's first bit sent with frame_sync=0 -> sync_err pulse; locked drops; bits are ignored until frame_sync=1, then lock is regained and ch_data updates correctly.
- Reset mid-frame: rst during slot 2 -> all outputs 0 next cycle, state HUNT; the following synced frame decodes correctly.
